uart_rx_ctrl: RTL
=================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencing controller for the UART receive path: detects the start bit, times mid-bit samples
//  from a 16x baud strobe, assembles DATA_BITS LSB-first, checks the stop bit, presents the byte
//  on a valid/ready interface with framing and overrun flags. Sits between baud generator/rx
//  synchroniser and the host-side consumer; replaces ad-hoc timer/counter/shift glue.
// PARAMETERS
//  OVERSAMPLE  16  strobes per bit period; power of 2, >=8; mid-bit = OVERSAMPLE/2
//  DATA_BITS   8   data bits per frame (5..8); no parity
// PORTS
//  clk          in   1          single system clock, all logic on posedge
//  reset        in   1          synchronous, ACTIVE-LOW (reset==0 resets on next posedge)
//  tick         in   1          1-cycle strobe at OVERSAMPLE x baud; all timing advances only on tick
//  rx           in   1          serial line, already 2-FF synchronised, idle high
//  data_out     out  DATA_BITS  received byte, stable while data_valid==1
//  data_valid   out  1          byte available; held until accepted
//  data_ready   in   1          consumer accepts when data_valid&&data_ready at posedge
//  frame_err    out  1          1-cycle pulse: stop bit sampled 0
//  overrun_err  out  1          1-cycle pulse: frame completed while holding reg full and not drained
//  busy         out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE, tick_cnt=0, bit_cnt=0, shreg=0, data_out=0,
//   data_valid=0, frame_err=0, overrun_err=0, busy=0. Overrides everything, incl. mid-frame.
//  States: IDLE, START, DATA, STOP, WAIT_HIGH.
//  IDLE: on tick with rx==0 -> START, tick_cnt=0. rx==0 without tick: no action.
//  START: tick_cnt++ per tick; at tick_cnt==OVERSAMPLE/2-1 tick: rx==0 -> DATA (tick_cnt=0,
//   bit_cnt=0); rx==1 -> IDLE (glitch rejected, no flags).
//  DATA: tick_cnt++ per tick; at tick_cnt==OVERSAMPLE-1 tick: shreg={rx,shreg[DATA_BITS-1:1]},
//   tick_cnt=0, bit_cnt++; after sample DATA_BITS-1 -> STOP. Counters wrap only as stated.
//  STOP: at tick_cnt==OVERSAMPLE-1 tick: rx==1 -> byte complete, IDLE; rx==0 -> frame_err=1
//   for exactly one cycle, byte discarded, -> WAIT_HIGH.
//  WAIT_HIGH: stay until rx==1 sampled on a tick -> IDLE (break/stuck-low never re-triggers).
//  Output stage (byte complete at cycle N):
//   - data_valid==0 at N: data_out<=shreg, data_valid=1 from N+1.
//   - data_valid==1 and data_ready==1 at N: old byte consumed, new byte loaded, valid stays 1.
//   - data_valid==1 and data_ready==0 at N: new byte dropped, old kept, overrun_err 1 cycle.
//   - accept with no new byte: data_valid=0 next cycle; data_out holds last value.
//  Latency: data_valid rises 1 clk after the stop-bit sample tick.
//  data_ready while data_valid==0 ignored. frame_err and overrun_err never both set.
// STRUCTURE
//  Shared include uart_defs.vh: state encodings (3-bit localparams), OVERSAMPLE default,
//   DATA_BITS default; reused by the transmit controller.
//  Sub-module uart_rx_hold: holding reg + valid/ready/overrun logic, ports load, din, data_out,
//   data_valid, data_ready, overrun_err. FSM, tick_cnt, bit_cnt, shreg stay in uart_rx_ctrl.
// TESTING (OVERSAMPLE=16, DATA_BITS=8, tick every 4 clk)
//  Frame 0xA5 (rx 0,1,0,1,0,0,1,0,1,1), data_ready=1 -> data_out=8'hA5, data_valid 1 clk,
//   no error flags, busy low after stop.
//  rx low for 5 ticks then high -> no byte, no flags, back to IDLE, busy pulse only.
//  Frame 0x3C with stop bit 0, rx held low 40 ticks -> frame_err one pulse, no data_valid,
//   no new frame started until rx high.
//  Two frames 0x11, 0x22 with data_ready=0 -> data_out=8'h11 held, overrun_err on 2nd;
//   then data_ready=1 -> valid drops next clk.
//  Second frame completes in same clk as accept of first -> data_out=8'h22, valid never drops.
//  reset=0 mid-DATA (after 3 bits) for 1 clk, then clean frame 0x5A -> only 0x5A delivered.

Source files
------------

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and frame defaults.
// The transmit controller reuses the same encodings and defaults.
package uart_rx_ctrl_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  function automatic logic state_busy(input rx_state_e s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/uart_rx_hold.sv
// Output holding register for received bytes: valid/ready handshake plus overrun
// detection when a new byte arrives while the previous one is still pending.
module uart_rx_hold
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] din,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 overrun_err
);

  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 valid_d, valid_q;
  logic                 overrun_d, overrun_q;

  // A consumer accept in the same cycle as a new byte frees the slot for it.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      if (!valid_q || data_ready) begin
        data_d  = din;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign overrun_err = overrun_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start-bit qualification, mid-bit sampling from an oversampled
// baud strobe, LSB-first assembly, stop-bit check, and hand-off to the holding register.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e            state_d, state_q;
  logic [TW-1:0]        tick_cnt_d, tick_cnt_q;
  logic [BW-1:0]        bit_cnt_d, bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_d, shreg_q;
  logic                 frame_err_d, frame_err_q;
  logic                 busy_d, busy_q;
  logic                 load;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!rx) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        // Re-check the line at mid start bit so short low glitches are rejected.
        ST_START: begin
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            if (!rx) begin
              state_d   = ST_DATA;
              bit_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_DATA: begin
          if (tick_cnt_q == TICK_LAST) begin
            shreg_d    = {rx, shreg_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        ST_STOP: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            if (rx) begin
              load    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        // A held-low line (break) must go high before another start bit is accepted.
        ST_WAIT_HIGH: begin
          if (rx) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = state_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  uart_rx_hold #(
    .DATA_BITS(DATA_BITS)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .din        (shreg_q),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun_err(overrun_err)
  );

  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule
